// File: rtl/csa_pipe_if.sv
// Streaming operand/result bundle for csa_pipe_adder.
// The sub signal exists only when CSA_SUB_EN is defined.
interface csa_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef CSA_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
`ifdef CSA_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder with valid/ready flow control and a global stall.
// Optional subtract mode is enabled by defining CSA_SUB_EN.
module csa_pipe_adder #(
  parameter int WIDTH         = 32,
  parameter int BLOCK         = 4,
  parameter int BLK_PER_STAGE = 2
) (
  input  logic        clk,
  input  logic        rst,
  csa_pipe_if.slave   bus
);
  localparam int NBLK   = WIDTH / BLOCK;
  localparam int STAGES = NBLK / BLK_PER_STAGE;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             v_q   [STAGES];
  logic             v_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;
  logic             advance_s;
  logic [WIDTH-1:0] b_eff_s;

  // Effective B operand: inverted in subtract mode, carry-in passes through unchanged
  always_comb begin
`ifdef CSA_SUB_EN
    if (bus.sub) begin
      b_eff_s = ~bus.b;
    end else begin
      b_eff_s = bus.b;
    end
`else
    b_eff_s = bus.b;
`endif
  end

  // One stall signal for the whole pipe: it moves only when the output slot can drain
  assign advance_s     = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  // Next-state for every stage: resolve this stage's groups by carry selection
  always_comb begin
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] ps;
    logic             pc;
    logic             pv;
    logic [BLOCK:0]   s0;
    logic [BLOCK:0]   s1;
    int               lo;
    ovf_d = 1'b0;
    for (int j = 0; j < STAGES; j++) begin
      if (j == 0) begin
        pa = bus.a;
        pb = b_eff_s;
        ps = {WIDTH{1'b0}};
        pc = bus.cin;
        pv = bus.in_valid;
      end else begin
        pa = a_q[j-1];
        pb = b_q[j-1];
        ps = sum_q[j-1];
        pc = c_q[j-1];
        pv = v_q[j-1];
      end
      for (int k = 0; k < BLK_PER_STAGE; k++) begin
        lo = (j * BLK_PER_STAGE + k) * BLOCK;
        // Both carry hypotheses are formed before the real carry is known
        s0 = {1'b0, pa[lo +: BLOCK]} + {1'b0, pb[lo +: BLOCK]};
        s1 = {1'b0, pa[lo +: BLOCK]} + {1'b0, pb[lo +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
        ps[lo +: BLOCK] = pc ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
        pc = pc ? s1[BLOCK] : s0[BLOCK];
      end
      a_d[j]   = pa;
      b_d[j]   = pb;
      sum_d[j] = ps;
      c_d[j]   = pc;
      v_d[j]   = pv;
    end
    ovf_d = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
  end

  // Stage registers: cleared by reset, frozen together while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < STAGES; j++) begin
        a_q[j]   <= {WIDTH{1'b0}};
        b_q[j]   <= {WIDTH{1'b0}};
        sum_q[j] <= {WIDTH{1'b0}};
        c_q[j]   <= 1'b0;
        v_q[j]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance_s) begin
      for (int j = 0; j < STAGES; j++) begin
        a_q[j]   <= a_d[j];
        b_q[j]   <= b_d[j];
        sum_q[j] <= sum_d[j];
        c_q[j]   <= c_d[j];
        v_q[j]   <= v_d[j];
      end
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed and streaming checks for csa_pipe_adder with a scoreboard of expected results.
// Subtract vectors are exercised when CSA_SUB_EN is defined.
module tb_csa_pipe_adder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  bit   lat_en;
  bit   accepted;
  logic [33:0] pend_exp;
  logic [33:0] exp_q[$];
  int          pc_q[$];

  csa_pipe_if #(.WIDTH(32)) bus ();

  csa_pipe_adder #(.WIDTH(32), .BLOCK(4), .BLK_PER_STAGE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Golden: plain wide addition, overflow from operand and result signs
  function automatic logic [33:0] model(input logic [31:0] a_i, input logic [31:0] b_i,
                                        input logic cin_i, input logic sub_i);
    logic [31:0] bp;
    logic [32:0] full;
    logic        o;
    bp   = sub_i ? ~b_i : b_i;
    full = {1'b0, a_i} + {1'b0, bp} + {32'd0, cin_i};
    o    = (a_i[31] == bp[31]) && (full[31] != a_i[31]);
    return {o, full[32], full[31:0]};
  endfunction

  task automatic tick();
    #2;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("stale", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        logic [33:0] e = exp_q.pop_front();
        int          p = pc_q.pop_front();
        chk("result", {30'd0, bus.ovf, bus.cout, bus.sum}, {30'd0, e});
        if (lat_en) chk("latency", 64'(cyc - p), 64'd4);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(pend_exp);
      pc_q.push_back(cyc);
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic cin_i,
                      input logic [33:0] e);
    bus.a        = a_i;
    bus.b        = b_i;
    bus.cin      = cin_i;
    pend_exp     = e;
    bus.in_valid = 1'b1;
    accepted     = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) tick();
    chk("accept", {63'd0, accepted}, 64'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; lat_en = 1'b1; accepted = 1'b0; pend_exp = 34'd0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.cin = 1'b0; bus.out_ready = 1'b1;
`ifdef CSA_SUB_EN
    bus.sub = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_sum", {32'd0, bus.sum}, 64'd0);
    chk("rst_cout_ovf", {62'd0, bus.cout, bus.ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;

    // Single beat: latency and wraparound to zero
    send(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    idle(6);
    chk("sb_empty_single", 64'(exp_q.size()), 64'd0);

    // Directed vectors back to back, hand-computed {ovf, cout, sum}
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 1'b0, 32'h8000_0000});
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b0, 1'b1, 32'hFFFF_FFFF});
    send(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
    send(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 1'b0, 32'h2345_6789});
    send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0100_0000});
    send(32'h0000_FF00, 32'h0000_00FF, 1'b1, {1'b0, 1'b0, 32'h0001_0000});
    idle(6);
    chk("sb_empty_directed", 64'(exp_q.size()), 64'd0);

    // Continuous stream at full rate
    for (int i = 0; i < 100; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc, 1'b0));
    end
    idle(6);
    chk("sb_empty_stream", 64'(exp_q.size()), 64'd0);

    // Backpressure with a full pipe
    lat_en = 1'b0;
    send(32'h0000_0010, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0000_0011});
    send(32'h0000_0020, 32'h0000_0002, 1'b0, {1'b0, 1'b0, 32'h0000_0022});
    send(32'h0000_0030, 32'h0000_0003, 1'b1, {1'b0, 1'b0, 32'h0000_0034});
    send(32'hFFFF_FFF0, 32'h0000_0010, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    bus.a = 32'h0000_0050; bus.b = 32'h0000_0005; bus.cin = 1'b0;
    pend_exp = {1'b0, 1'b0, 32'h0000_0055};
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stall_hold", {30'd0, bus.ovf, bus.cout, bus.sum}, {30'd0, exp_q[0]});
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    accepted = 1'b0;
    tick();
    chk("release_accept", {63'd0, accepted}, 64'd1);
    idle(8);
    chk("sb_empty_bp", 64'(exp_q.size()), 64'd0);
    lat_en = 1'b1;

    // Reset with beats in flight
    send(32'h0000_0100, 32'h0000_0001, 1'b0, {1'b0, 1'b0, 32'h0000_0101});
    send(32'h0000_0200, 32'h0000_0002, 1'b0, {1'b0, 1'b0, 32'h0000_0202});
    send(32'h0000_0300, 32'h0000_0003, 1'b0, {1'b0, 1'b0, 32'h0000_0303});
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_sum", {32'd0, bus.sum}, 64'd0);
    chk("mid_rst_cout_ovf", {62'd0, bus.cout, bus.ovf}, 64'd0);
    exp_q.delete();
    pc_q.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    send(32'h0000_0007, 32'h0000_0008, 1'b0, {1'b0, 1'b0, 32'h0000_000F});
    idle(6);
    chk("sb_empty_rst", 64'(exp_q.size()), 64'd0);

`ifdef CSA_SUB_EN
    // Subtract mode
    bus.sub = 1'b1;
    send(32'h0000_0005, 32'h0000_0007, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    send(32'h8000_0000, 32'h0000_0001, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    bus.sub = 1'b0;
    idle(6);
    chk("sb_empty_sub", 64'(exp_q.size()), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
